display_scan_ctrl: RTL and testbench

- Time-multiplexes NUM_DIGITS BCD digits (HH:MM for the alarm clock) onto the single shared 7-segment decoder and the common segment bus, driving one active-low anode at a time.
- Sits between the timekeeping/alarm-setting logic and the segment decoder.
- Provides frame-synchronous double-buffered digit loading, per-digit blanking and blinking, a dead-time gap against ghosting, and suppression of non-BCD codes.

---
 rtl/display_scan_ctrl.sv | 143 ++++++++++++++
 tb/tb_display_scan_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: multiplexes NUM_DIGITS BCD digits onto one decoder/segment bus, one active-low anode at a time.
// Optional macro LEADING_ZERO_BLANK_EN: blank the leftmost digit when its code is 0.
`default_nettype none

module display_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 100000,
  parameter int ON_TICKS     = 4,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [4*NUM_DIGITS-1:0]       digits_in,
  input  logic                          load,
  input  logic [NUM_DIGITS-1:0]         blank_mask,
  input  logic [NUM_DIGITS-1:0]         blink_mask,
  output logic [3:0]                    number_out,
  output logic [NUM_DIGITS-1:0]         anode_n,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_sel,
  output logic                          frame_done
);

  localparam int SELW = $clog2(NUM_DIGITS);
  localparam int PW   = $clog2(SCAN_DIV);
  localparam int TW   = (ON_TICKS > 1) ? $clog2(ON_TICKS) : 1;
  localparam int BW   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  typedef enum logic {S_DEAD = 1'b0, S_DRIVE = 1'b1} state_t;

  state_t                  r_state;
  logic [PW-1:0]           r_presc;
  logic [TW-1:0]           r_tcnt;
  logic [SELW-1:0]         r_sel;
  logic [4*NUM_DIGITS-1:0] r_shadow;
  logic [4*NUM_DIGITS-1:0] r_pending;
  logic                    r_pend_flag;
  logic                    r_phase;
  logic [BW-1:0]           r_bcnt;
  logic [NUM_DIGITS-1:0]   r_anode_n;
  logic [3:0]              r_number;

  logic                    w_tick;
  logic                    w_last_sel;
  logic                    w_slot_end;
  logic                    w_wrap;
  logic [SELW-1:0]         w_sel_nxt;
  logic [4*NUM_DIGITS-1:0] w_shadow_nxt;
  logic [3:0]              w_code;
  logic                    w_en;
  logic [NUM_DIGITS-1:0]   w_onehot;

  assign w_tick     = (r_presc == PW'(SCAN_DIV - 1));
  assign w_last_sel = (r_sel == SELW'(NUM_DIGITS - 1));
  assign w_slot_end = w_tick && (r_state == S_DRIVE) && (r_tcnt == TW'(ON_TICKS - 1));
  assign w_wrap     = w_slot_end && w_last_sel;
  assign w_sel_nxt  = w_slot_end ? (w_last_sel ? '0 : r_sel + 1'b1) : r_sel;
  assign w_code     = r_shadow[4*int'(r_sel) +: 4];
  assign w_onehot   = NUM_DIGITS'(1) << r_sel;

  // A load landing on the wrap cycle bypasses pending so digit 0 of the new frame already shows it.
  always_comb begin
    w_shadow_nxt = r_shadow;
    if (w_wrap) begin
      if (load)
        w_shadow_nxt = digits_in;
      else if (r_pend_flag)
        w_shadow_nxt = r_pending;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  assign w_en = !blank_mask[r_sel] && !(blink_mask[r_sel] && !r_phase) &&
                (w_code <= 4'd9) && !(w_last_sel && (w_code == 4'd0));
`else
  assign w_en = !blank_mask[r_sel] && !(blink_mask[r_sel] && !r_phase) &&
                (w_code <= 4'd9);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_DEAD;
      r_presc     <= '0;
      r_tcnt      <= '0;
      r_sel       <= '0;
      r_shadow    <= '0;
      r_pending   <= '0;
      r_pend_flag <= 1'b0;
      r_phase     <= 1'b1;
      r_bcnt      <= '0;
      r_anode_n   <= '1;
      r_number    <= 4'd0;
    end else begin
      r_presc  <= w_tick ? '0 : r_presc + 1'b1;
      r_shadow <= w_shadow_nxt;
      // Decoder input follows the digit index at the same edge so it settles during DEAD.
      r_number <= w_shadow_nxt[4*int'(w_sel_nxt) +: 4];

      if (load)
        r_pending <= digits_in;
      if (w_wrap)
        r_pend_flag <= 1'b0;
      else if (load)
        r_pend_flag <= 1'b1;

      if (w_wrap) begin
        if (r_bcnt == BW'(BLINK_FRAMES - 1)) begin
          r_bcnt  <= '0;
          r_phase <= ~r_phase;
        end else begin
          r_bcnt <= r_bcnt + 1'b1;
        end
      end

      if (w_tick) begin
        case (r_state)
          S_DEAD: begin
            r_state   <= S_DRIVE;
            r_tcnt    <= '0;
            r_anode_n <= w_en ? ~w_onehot : '1;
          end
          S_DRIVE: begin
            if (r_tcnt == TW'(ON_TICKS - 1)) begin
              r_state   <= S_DEAD;
              r_anode_n <= '1;
              r_sel     <= w_sel_nxt;
            end else begin
              r_tcnt <= r_tcnt + 1'b1;
            end
          end
          default: r_state <= S_DEAD;
        endcase
      end
    end
  end

  assign number_out = r_number;
  assign anode_n    = r_anode_n;
  assign digit_sel  = r_sel;
  assign frame_done = w_wrap;

endmodule

`default_nettype wire

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl: frame-level scoreboard bench for display_scan_ctrl (4 digits, SCAN_DIV=4, ON_TICKS=2).
`default_nettype none

module tb_display_scan_ctrl;

  localparam int ND = 4;
  localparam int SD = 4;
  localparam int OT = 2;
  localparam int BF = 2;
  localparam int SLOT  = (1 + OT) * SD;
  localparam int FRAME = ND * SLOT;

  typedef struct packed {
    logic [1:0] sel;
    logic [3:0] num;
    logic       lit;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [15:0] digits_in;
  logic        load;
  logic [3:0]  blank_mask;
  logic [3:0]  blink_mask;
  logic [3:0]  number_out;
  logic [3:0]  anode_n;
  logic [1:0]  digit_sel;
  logic        frame_done;

  exp_t        sb_q[$];
  int          n_chk;
  int          n_err;

  logic [15:0] m_shadow;
  logic [15:0] m_pending;
  bit          m_flag;
  bit          m_phase;
  int          m_bcnt;

  display_scan_ctrl #(
    .NUM_DIGITS  (ND),
    .SCAN_DIV    (SD),
    .ON_TICKS    (OT),
    .BLINK_FRAMES(BF)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .digits_in (digits_in),
    .load      (load),
    .blank_mask(blank_mask),
    .blink_mask(blink_mask),
    .number_out(number_out),
    .anode_n   (anode_n),
    .digit_sel (digit_sel),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m_shadow  = 16'h0;
    m_pending = 16'h0;
    m_flag    = 1'b0;
    m_phase   = 1'b1;
    m_bcnt    = 0;
  endtask

  // Runs one frame from the start of digit 0's DEAD slot; optional load at interval load_at,
  // optional asynchronous reset at interval abort_at.
  task automatic run_frame(input bit do_load, input logic [15:0] val, input int load_at,
                           input int abort_at);
    exp_t       e;
    logic [3:0] exp_an;
    int         slot;
    int         pos;
    for (int d = 0; d < ND; d++) begin
      e.sel = 2'(d);
      e.num = m_shadow[4*d +: 4];
      e.lit = !blank_mask[d] && !(blink_mask[d] && !m_phase) && (e.num <= 4'd9);
`ifdef LEADING_ZERO_BLANK_EN
      if (d == ND - 1 && e.num == 4'd0)
        e.lit = 1'b0;
`endif
      sb_q.push_back(e);
    end
    e = '0;
    for (int i = 0; i < FRAME; i++) begin
      load      = do_load && (i == load_at);
      digits_in = val;
      if (i == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk("rst_anode", 32'(anode_n), 32'hF);
        chk("rst_sel", 32'(digit_sel), 32'h0);
        chk("rst_num", 32'(number_out), 32'h0);
        chk("rst_fdone", 32'(frame_done), 32'h0);
        load = 1'b0;
        sb_q.delete();
        model_reset();
        return;
      end
      #1;
      slot = i / SLOT;
      pos  = i % SLOT;
      if (pos == 0) begin
        if (sb_q.size() == 0)
          chk("sb_empty", 32'h1, 32'h0);
        else
          e = sb_q.pop_front();
      end
      if (pos == 0 || pos == SD - 1 || pos == SD || pos == SLOT - 1) begin
        exp_an = (pos < SD || !e.lit) ? 4'hF : ~(4'b0001 << e.sel);
        chk("sel", 32'(digit_sel), 32'(e.sel));
        chk("num", 32'(number_out), 32'(e.num));
        chk("anode", 32'(anode_n), 32'(exp_an));
        chk("fdone", 32'(frame_done), 32'(slot == ND - 1 && pos == SLOT - 1));
      end
      @(negedge clk);
    end
    load = 1'b0;
    if (do_load && load_at == FRAME - 1) begin
      m_shadow  = val;
      m_pending = val;
      m_flag    = 1'b0;
    end else begin
      if (do_load) begin
        m_pending = val;
        m_flag    = 1'b1;
      end
      if (m_flag) begin
        m_shadow = m_pending;
        m_flag   = 1'b0;
      end
    end
    if (m_bcnt == BF - 1) begin
      m_bcnt  = 0;
      m_phase = ~m_phase;
    end else begin
      m_bcnt++;
    end
  endtask

  initial begin
    n_chk      = 0;
    n_err      = 0;
    rst_n      = 1'b1;
    load       = 1'b0;
    digits_in  = 16'h0;
    blank_mask = 4'h0;
    blink_mask = 4'h0;
    model_reset();
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("init_anode", 32'(anode_n), 32'hF);
    chk("init_num", 32'(number_out), 32'h0);
    chk("init_sel", 32'(digit_sel), 32'h0);
    chk("init_fdone", 32'(frame_done), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    run_frame(1'b0, 16'h0, -1, -1);
    run_frame(1'b1, 16'h1234, 20, -1);
    run_frame(1'b1, 16'h0859, FRAME - 1, -1);
    blink_mask = 4'b0011;
    run_frame(1'b0, 16'h0, -1, -1);
    run_frame(1'b0, 16'h0, -1, -1);
    blank_mask = 4'b1000;
    run_frame(1'b0, 16'h0, -1, -1);
    blank_mask = 4'b0000;
    blink_mask = 4'b0000;
    run_frame(1'b1, 16'h00A0, 5, -1);
    run_frame(1'b0, 16'h0, -1, -1);
    run_frame(1'b0, 16'h0, -1, 2 * SLOT + SD + 2);
    @(negedge clk);
    rst_n = 1'b1;
    run_frame(1'b0, 16'h0, -1, -1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
